// File: rtl/mm_accel_pkg.sv
// Shared definitions for the matrix-multiplication accelerator controller.
// Holds the one-hot state encodings, size defaults and a clog2 helper used to
// derive index widths.
package mm_accel_pkg;

  localparam int unsigned MMaxDefault = 4;
  localparam int unsigned KMaxDefault = 4;

  localparam logic [5:0] OhIdle    = 6'b000001;
  localparam logic [5:0] OhLoadA   = 6'b000010;
  localparam logic [5:0] OhMac     = 6'b000100;
  localparam logic [5:0] OhWaitMac = 6'b001000;
  localparam logic [5:0] OhStoreC  = 6'b010000;
  localparam logic [5:0] OhDone    = 6'b100000;

  typedef enum logic [5:0] {
    StIdle    = OhIdle,
    StLoadA   = OhLoadA,
    StMac     = OhMac,
    StWaitMac = OhWaitMac,
    StStoreC  = OhStoreC,
    StDone    = OhDone
  } state_e;

  // Ceiling log2, never below 1 so single-entry ranges still get a 1-bit index.
  function automatic int unsigned clog2(input int unsigned val);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(val)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/mm_idx_counter.sv
// Index counter with run-time limit.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : force count to 0 (wins over inc)
//   inc        : advance; wraps to 0 on the last value
//   limit      : number of values, count runs 0..limit-1
//   count      : current index
//   last       : count == limit-1
module mm_idx_counter #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  input  logic [W:0]   limit,
  output logic [W-1:0] count,
  output logic         last
);

  logic [W-1:0] count_q, count_d;

  // A zero limit (post-reset) makes limit-1 all ones, which count never reaches.
  assign last  = ({1'b0, count_q} == (limit - (W+1)'(1)));
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = last ? '0 : count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mm_accel_ctrl.sv
// Row-by-row A x B -> C sequencing controller.
// For every A row: LOAD_A, cfg_k MAC beats, WAIT_MAC drain, STORE_C.
// Ports:
//   clk, rst_n              : clock, synchronous active-low reset
//   start, cfg_rows, cfg_k  : launch request and run-time dimensions
//   abort                   : cancel the operation in progress
//   fetch_A_ready, fetch_B_ready, MACs_ready, store_C_ready : handshakes
//   fetch_A, register_enable, MACs_reset, fetch_B, MACs_enable, store_C : controls
//   row_idx, k_idx          : current A/C row and B row (A element select)
//   busy, finish, err       : status; finish and err are one-cycle pulses
module mm_accel_ctrl
  import mm_accel_pkg::*;
#(
  parameter int unsigned M_MAX = MMaxDefault,
  parameter int unsigned K_MAX = KMaxDefault,
  parameter int unsigned RW    = clog2(M_MAX),
  parameter int unsigned KW    = clog2(K_MAX)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [RW:0]   cfg_rows,
  input  logic [KW:0]   cfg_k,
  input  logic          abort,
  input  logic          fetch_A_ready,
  input  logic          fetch_B_ready,
  input  logic          MACs_ready,
  input  logic          store_C_ready,
  output logic          fetch_A,
  output logic          register_enable,
  output logic          MACs_reset,
  output logic          fetch_B,
  output logic          MACs_enable,
  output logic          store_C,
  output logic [RW-1:0] row_idx,
  output logic [KW-1:0] k_idx,
  output logic          busy,
  output logic          finish,
  output logic          err
);

  state_e      state_q, state_d;
  logic [RW:0] rows_q, rows_d;
  logic [KW:0] k_q, k_d;
  logic        err_q, err_d;

  logic cfg_valid, accept, abort_act;
  logic row_last, k_last, row_inc, k_inc;

  assign cfg_valid = (cfg_rows >= (RW+1)'(1)) && (cfg_rows <= (RW+1)'(M_MAX)) &&
                     (cfg_k >= (KW+1)'(1)) && (cfg_k <= (KW+1)'(K_MAX));

  // Abort only acts outside IDLE; in IDLE it merely masks start.
  assign abort_act = abort && (state_q != StIdle);
  assign accept    = (state_q == StIdle) && start && !abort && cfg_valid;

  assign k_inc   = (state_q == StMac) && fetch_B_ready && !abort;
  assign row_inc = (state_q == StStoreC) && store_C_ready && !abort;

  mm_idx_counter #(
    .W (RW)
  ) u_row_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept || abort_act),
    .inc   (row_inc),
    .limit (rows_q),
    .count (row_idx),
    .last  (row_last)
  );

  mm_idx_counter #(
    .W (KW)
  ) u_k_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept || abort_act),
    .inc   (k_inc),
    .limit (k_q),
    .count (k_idx),
    .last  (k_last)
  );

  always_comb begin
    state_d = state_q;
    rows_d  = rows_q;
    k_d     = k_q;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          if (cfg_valid) begin
            rows_d  = cfg_rows;
            k_d     = cfg_k;
            state_d = StLoadA;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StLoadA: begin
        if (fetch_A_ready) state_d = StMac;
      end
      StMac: begin
        if (fetch_B_ready && k_last) state_d = StWaitMac;
      end
      StWaitMac: begin
        if (MACs_ready) state_d = StStoreC;
      end
      StStoreC: begin
        if (store_C_ready) state_d = row_last ? StDone : StLoadA;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    if (abort_act) begin
      state_d = StIdle;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      rows_q  <= '0;
      k_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rows_q  <= rows_d;
      k_q     <= k_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    fetch_A         = (state_q == StLoadA);
    MACs_reset      = (state_q == StLoadA);
    register_enable = (state_q == StLoadA) && fetch_A_ready && !abort;
    fetch_B         = (state_q == StMac);
    MACs_enable     = k_inc;
    store_C         = (state_q == StStoreC);
    busy            = (state_q != StIdle);
    finish          = (state_q == StDone);
    err             = err_q;
  end

endmodule

// File: tb/tb_mm_accel_ctrl.sv
module tb_mm_accel_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [2:0] cfg_rows;
  logic [2:0] cfg_k;
  logic       abort;
  logic       fetch_A_ready, fetch_B_ready, MACs_ready, store_C_ready;
  logic       fetch_A, register_enable, MACs_reset, fetch_B, MACs_enable, store_C;
  logic [1:0] row_idx;
  logic [1:0] k_idx;
  logic       busy, finish, err;

  mm_accel_ctrl #(
    .M_MAX (4),
    .K_MAX (4)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .cfg_rows        (cfg_rows),
    .cfg_k           (cfg_k),
    .abort           (abort),
    .fetch_A_ready   (fetch_A_ready),
    .fetch_B_ready   (fetch_B_ready),
    .MACs_ready      (MACs_ready),
    .store_C_ready   (store_C_ready),
    .fetch_A         (fetch_A),
    .register_enable (register_enable),
    .MACs_reset      (MACs_reset),
    .fetch_B         (fetch_B),
    .MACs_enable     (MACs_enable),
    .store_C         (store_C),
    .row_idx         (row_idx),
    .k_idx           (k_idx),
    .busy            (busy),
    .finish          (finish),
    .err             (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int rows;
    int k;
    int stall_at;
    int stall_len;
    int busy_start;
    int exp_done;
    int bad;
  } vec_t;

  typedef struct {
    int row;
    int k;
  } beat_t;

  vec_t  vecs [9];
  beat_t beat_q [$];
  int    store_q [$];
  int    n_cmp;
  int    n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected MAC beats and stores for a complete operation.
  task automatic push_op(input int rows, input int k);
    beat_t b;
    for (int r = 0; r < rows; r++) begin
      for (int kk = 0; kk < k; kk++) begin
        b.row = r;
        b.k   = kk;
        beat_q.push_back(b);
      end
      store_q.push_back(r);
    end
  endtask

  // Sample point: mid-cycle, after inputs have settled.
  task automatic observe();
    beat_t b;
    int    r;
    #2;
    if (MACs_enable === 1'b1) begin
      if (beat_q.size() == 0) chk("beat_unexpected", MACs_enable, 0);
      else begin
        b = beat_q.pop_front();
        chk("beat_row", row_idx, b.row);
        chk("beat_k", k_idx, b.k);
      end
    end
    if (store_C === 1'b1) begin
      if (store_q.size() == 0) chk("store_unexpected", store_C, 0);
      else begin
        r = store_q.pop_front();
        chk("store_row", row_idx, r);
      end
    end
    if (fetch_A === 1'b1) begin
      chk("reg_en", register_enable, fetch_A_ready & ~abort);
      chk("macs_reset", MACs_reset, 1);
    end
    if (fetch_B === 1'b1) chk("mac_en", MACs_enable, fetch_B_ready & ~abort);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input vec_t v);
    int   done_c;
    logic [1:0] k_prev;
    logic stall;
    push_op(v.rows, v.k);
    cfg_rows = 3'(v.rows);
    cfg_k    = 3'(v.k);
    start    = 1'b1;
    observe();
    chk("busy_at_start", busy, 0);
    advance();
    start    = 1'b0;
    // Changing cfg while busy must have no effect.
    cfg_rows = 3'd1;
    cfg_k    = 3'd1;
    done_c   = -1;
    k_prev   = '0;
    for (int c = 1; c <= 200; c++) begin
      stall = (v.stall_len > 0) && (c >= v.stall_at) && (c < v.stall_at + v.stall_len);
      fetch_B_ready = !stall;
      start = (c == v.busy_start);
      observe();
      if (c == 1) chk("busy_c1", busy, 1);
      if (stall) begin
        chk("stall_mac_en", MACs_enable, 0);
        if (c > v.stall_at) chk("stall_k_hold", k_idx, k_prev);
      end
      k_prev = k_idx;
      if (finish === 1'b1) begin
        done_c = c;
        advance();
        break;
      end
      advance();
    end
    start = 1'b0;
    fetch_B_ready = 1'b1;
    chk("done_cycle", done_c, v.exp_done);
    observe();
    chk("post_finish", finish, 0);
    chk("post_busy", busy, 0);
    chk("post_row", row_idx, 0);
    chk("post_k", k_idx, 0);
    chk("post_err", err, 0);
    advance();
    chk("beats_left", beat_q.size(), 0);
    chk("stores_left", store_q.size(), 0);
    beat_q.delete();
    store_q.delete();
  endtask

  task automatic bad_start(input int rows, input int k);
    cfg_rows = 3'(rows);
    cfg_k    = 3'(k);
    start    = 1'b1;
    observe();
    advance();
    start = 1'b0;
    observe();
    chk("bad_err", err, 1);
    chk("bad_busy", busy, 0);
    advance();
    observe();
    chk("bad_err_once", err, 0);
    chk("bad_busy2", busy, 0);
    advance();
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    vecs[0] = '{rows: 4, k: 4, stall_at: 0, stall_len: 0, busy_start: 5, exp_done: 29, bad: 0};
    vecs[1] = '{rows: 2, k: 3, stall_at: 3, stall_len: 2, busy_start: 0, exp_done: 15, bad: 0};
    vecs[2] = '{rows: 1, k: 0, stall_at: 0, stall_len: 0, busy_start: 0, exp_done: 0,  bad: 1};
    vecs[3] = '{rows: 5, k: 2, stall_at: 0, stall_len: 0, busy_start: 0, exp_done: 0,  bad: 1};
    vecs[4] = '{rows: 1, k: 1, stall_at: 0, stall_len: 0, busy_start: 0, exp_done: 5,  bad: 0};
    vecs[5] = '{rows: 0, k: 2, stall_at: 0, stall_len: 0, busy_start: 0, exp_done: 0,  bad: 1};
    vecs[6] = '{rows: 3, k: 2, stall_at: 0, stall_len: 0, busy_start: 0, exp_done: 16, bad: 0};
    vecs[7] = '{rows: 4, k: 1, stall_at: 0, stall_len: 0, busy_start: 0, exp_done: 17, bad: 0};
    vecs[8] = '{rows: 2, k: 5, stall_at: 0, stall_len: 0, busy_start: 0, exp_done: 0,  bad: 1};

    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    cfg_rows = 3'd0;
    cfg_k    = 3'd0;
    fetch_A_ready = 1'b1;
    fetch_B_ready = 1'b1;
    MACs_ready    = 1'b1;
    store_C_ready = 1'b1;
    #1;
    advance();
    advance();
    observe();
    chk("reset_outs", {fetch_A, register_enable, MACs_reset, fetch_B, MACs_enable,
                       store_C, busy, finish, err}, 0);
    chk("reset_row", row_idx, 0);
    chk("reset_k", k_idx, 0);
    rst_n = 1'b1;
    advance();

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].bad != 0) bad_start(vecs[i].rows, vecs[i].k);
      else run_op(vecs[i]);
    end

    // start together with abort in IDLE is ignored.
    cfg_rows = 3'd2;
    cfg_k    = 3'd2;
    start    = 1'b1;
    abort    = 1'b1;
    observe();
    advance();
    start = 1'b0;
    abort = 1'b0;
    observe();
    chk("idle_abort_busy", busy, 0);
    chk("idle_abort_err", err, 0);
    advance();

    // Abort during row 1 MAC (k_idx=1) with fetch_B_ready high.
    push_op(2, 3);
    cfg_rows = 3'd2;
    cfg_k    = 3'd3;
    start    = 1'b1;
    observe();
    advance();
    start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      observe();
      advance();
    end
    abort = 1'b1;
    observe();
    chk("abort_row", row_idx, 1);
    chk("abort_k", k_idx, 1);
    chk("abort_no_enable", MACs_enable, 0);
    advance();
    abort = 1'b0;
    observe();
    chk("abort_busy", busy, 0);
    chk("abort_err", err, 1);
    chk("abort_finish", finish, 0);
    chk("abort_row0", row_idx, 0);
    chk("abort_k0", k_idx, 0);
    advance();
    observe();
    chk("abort_err_once", err, 0);
    advance();
    beat_q.delete();
    store_q.delete();

    // Reset for one cycle while in STORE_C of row 0.
    push_op(2, 2);
    cfg_rows = 3'd2;
    cfg_k    = 3'd2;
    start    = 1'b1;
    observe();
    advance();
    start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      observe();
      advance();
    end
    rst_n = 1'b0;
    observe();
    chk("rst_in_store", store_C, 1);
    advance();
    rst_n = 1'b1;
    observe();
    chk("rst_mid_outs", {fetch_A, register_enable, MACs_reset, fetch_B, MACs_enable,
                         store_C, busy, finish, err}, 0);
    chk("rst_mid_row", row_idx, 0);
    chk("rst_mid_k", k_idx, 0);
    advance();
    beat_q.delete();
    store_q.delete();
    run_op(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
